// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus (CDB) among N_FU execution units. Each unit
// parks its completed result in a one-entry slot through a valid/ready
// handshake. Each cycle one pending slot is picked and driven onto the
// registered CDB outputs that the reservation stations snoop. A branch
// mispredict squashes pending speculative results.
//
// Optional feature macro: CDB_ARB_AGE_PRIORITY_EN
//   defined   -> grant the oldest eligible slot (wrap-safe issue-ID compare,
//                ties to the lowest index); rr_ptr is kept up to date but unused.
//   undefined -> round-robin starting after the last granted index.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low
//   req_valid/ready     per-FU handshake (ready is combinational)
//   req_data/reg_id/iss_id/spec  per-FU result fields, FU k in slice k
//   prediction_failed   squash speculative slots and incoming spec results
//   prediction_success  clear speculative marks
//   CDB, CDB_REG_ID, CDB_FU_ID, CDB_ISS_ID, cdb_valid, grant_fu  registered bus
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N_FU       = 4,
    parameter int FU_ID_BASE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_FU-1:0]      req_valid,
    output logic [N_FU-1:0]      req_ready,
    input  logic [N_FU*64-1:0]   req_data,
    input  logic [N_FU*5-1:0]    req_reg_id,
    input  logic [N_FU*32-1:0]   req_iss_id,
    input  logic [N_FU-1:0]      req_spec,
    input  logic                 prediction_failed,
    input  logic                 prediction_success,
    output logic [63:0]          CDB,
    output logic [4:0]           CDB_REG_ID,
    output logic [3:0]           CDB_FU_ID,
    output logic [31:0]          CDB_ISS_ID,
    output logic                 cdb_valid,
    output logic [N_FU-1:0]      grant_fu
);

    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    // Slot state
    logic [N_FU-1:0] slot_valid_q, slot_valid_d;
    logic [N_FU-1:0] slot_spec_q,  slot_spec_d;
    logic [63:0]     slot_data_q [N_FU];
    logic [63:0]     slot_data_d [N_FU];
    logic [4:0]      slot_reg_q  [N_FU];
    logic [4:0]      slot_reg_d  [N_FU];
    logic [31:0]     slot_iss_q  [N_FU];
    logic [31:0]     slot_iss_d  [N_FU];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Registered bus
    logic [63:0]     cdb_q,       cdb_d;
    logic [4:0]      cdb_reg_q,   cdb_reg_d;
    logic [3:0]      cdb_fu_q,    cdb_fu_d;
    logic [31:0]     cdb_iss_q,   cdb_iss_d;
    logic            cdb_valid_q, cdb_valid_d;
    logic [N_FU-1:0] grant_fu_q,  grant_fu_d;

    // Combinational helpers
    logic [N_FU-1:0]  eligible_s;
    logic             grant_any_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [N_FU-1:0]  grant_oh_s;
    logic [N_FU-1:0]  ready_s;
    logic [N_FU-1:0]  load_s;
`ifndef CDB_ARB_AGE_PRIORITY_EN
    logic [IDX_W-1:0] cand_s;
`endif

    // Grant selection among valid slots that are not being squashed
    always_comb begin
        eligible_s  = slot_valid_q & ~(slot_spec_q & {N_FU{prediction_failed}});
        grant_any_s = 1'b0;
        grant_idx_s = '0;
`ifdef CDB_ARB_AGE_PRIORITY_EN
        // Ascending scan with strict "older" test keeps ties on the lowest index
        for (int k = 0; k < N_FU; k++) begin
            if (!eligible_s[k]) begin
                grant_idx_s = grant_idx_s;
            end else if (!grant_any_s) begin
                grant_any_s = 1'b1;
                grant_idx_s = IDX_W'(k);
            end else if ($signed(slot_iss_q[k] - slot_iss_q[grant_idx_s]) < 32'sd0) begin
                grant_idx_s = IDX_W'(k);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
`else
        cand_s = '0;
        // Search rr_ptr+1 .. rr_ptr+N_FU (last is rr_ptr itself), first hit wins
        for (int off = 1; off <= N_FU; off++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + off) % N_FU);
            if (!grant_any_s && eligible_s[cand_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
`endif
        grant_oh_s = '0;
        if (grant_any_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // Ready: slot empty or draining this cycle; forced low while in reset
    always_comb begin
        if (!reset) begin
            ready_s = '0;
        end else begin
            ready_s = ~slot_valid_q | grant_oh_s;
        end
    end

    assign req_ready = ready_s;

    // Slot next state: load, drain, squash, or clear speculative mark
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_spec_d  = slot_spec_q;
        slot_data_d  = slot_data_q;
        slot_reg_d   = slot_reg_q;
        slot_iss_d   = slot_iss_q;
        load_s       = '0;
        for (int k = 0; k < N_FU; k++) begin
            // Register-0 results and spec results under a mispredict are swallowed
            load_s[k] = req_valid[k] && ready_s[k] &&
                        (req_reg_id[k*5 +: 5] != 5'd0) &&
                        !(prediction_failed && req_spec[k]);
            if (load_s[k]) begin
                slot_valid_d[k] = 1'b1;
                slot_spec_d[k]  = req_spec[k] && !prediction_success;
                slot_data_d[k]  = req_data[k*64 +: 64];
                slot_reg_d[k]   = req_reg_id[k*5 +: 5];
                slot_iss_d[k]   = req_iss_id[k*32 +: 32];
            end else if (grant_oh_s[k] || (prediction_failed && slot_spec_q[k])) begin
                slot_valid_d[k] = 1'b0;
                slot_spec_d[k]  = 1'b0;
            end else if (prediction_success) begin
                slot_spec_d[k]  = 1'b0;
            end else begin
                slot_spec_d[k]  = slot_spec_q[k];
            end
        end
    end

    // Pointer and bus next state
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_d       = 64'd0;
        cdb_reg_d   = 5'd0;
        cdb_fu_d    = 4'd0;
        cdb_iss_d   = 32'd0;
        cdb_valid_d = 1'b0;
        grant_fu_d  = '0;
        if (grant_any_s) begin
            rr_ptr_d    = grant_idx_s;
            cdb_d       = slot_data_q[grant_idx_s];
            cdb_reg_d   = slot_reg_q[grant_idx_s];
            cdb_fu_d    = 4'(FU_ID_BASE + int'(grant_idx_s));
            cdb_iss_d   = slot_iss_q[grant_idx_s];
            cdb_valid_d = 1'b1;
            grant_fu_d  = grant_oh_s;
        end else begin
            rr_ptr_d    = rr_ptr_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_valid_q <= '0;
            slot_spec_q  <= '0;
            for (int k = 0; k < N_FU; k++) begin
                slot_data_q[k] <= 64'd0;
                slot_reg_q[k]  <= 5'd0;
                slot_iss_q[k]  <= 32'd0;
            end
            rr_ptr_q    <= IDX_W'(N_FU - 1);
            cdb_q       <= 64'd0;
            cdb_reg_q   <= 5'd0;
            cdb_fu_q    <= 4'd0;
            cdb_iss_q   <= 32'd0;
            cdb_valid_q <= 1'b0;
            grant_fu_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_spec_q  <= slot_spec_d;
            slot_data_q  <= slot_data_d;
            slot_reg_q   <= slot_reg_d;
            slot_iss_q   <= slot_iss_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_q        <= cdb_d;
            cdb_reg_q    <= cdb_reg_d;
            cdb_fu_q     <= cdb_fu_d;
            cdb_iss_q    <= cdb_iss_d;
            cdb_valid_q  <= cdb_valid_d;
            grant_fu_q   <= grant_fu_d;
        end
    end

    assign CDB        = cdb_q;
    assign CDB_REG_ID = cdb_reg_q;
    assign CDB_FU_ID  = cdb_fu_q;
    assign CDB_ISS_ID = cdb_iss_q;
    assign cdb_valid  = cdb_valid_q;
    assign grant_fu   = grant_fu_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed self-checking bench for cdb_arbiter (N_FU=4, FU_ID_BASE=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*64-1:0]   req_data;
    logic [N*5-1:0]    req_reg_id;
    logic [N*32-1:0]   req_iss_id;
    logic [N-1:0]      req_spec;
    logic              prediction_failed;
    logic              prediction_success;
    logic [63:0]       CDB;
    logic [4:0]        CDB_REG_ID;
    logic [3:0]        CDB_FU_ID;
    logic [31:0]       CDB_ISS_ID;
    logic              cdb_valid;
    logic [N-1:0]      grant_fu;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.N_FU(N), .FU_ID_BASE(1)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_data           (req_data),
        .req_reg_id         (req_reg_id),
        .req_iss_id         (req_iss_id),
        .req_spec           (req_spec),
        .prediction_failed  (prediction_failed),
        .prediction_success (prediction_success),
        .CDB                (CDB),
        .CDB_REG_ID         (CDB_REG_ID),
        .CDB_FU_ID          (CDB_FU_ID),
        .CDB_ISS_ID         (CDB_ISS_ID),
        .cdb_valid          (cdb_valid),
        .grant_fu           (grant_fu)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [63:0] d, input logic [4:0] r,
                           input logic [31:0] iss, input logic sp);
        req_data[k*64 +: 64]   = d;
        req_reg_id[k*5 +: 5]   = r;
        req_iss_id[k*32 +: 32] = iss;
        req_spec[k]            = sp;
        req_valid[k]           = 1'b1;
    endtask

    task automatic idle_inputs();
        req_valid          = '0;
        req_spec           = '0;
        prediction_failed  = 1'b0;
        prediction_success = 1'b0;
    endtask

    task automatic check_bus(input string tag, input logic [3:0] fu, input logic [4:0] r,
                             input logic [31:0] iss);
        check_eq({tag, "_valid"}, 64'(cdb_valid),  64'd1);
        check_eq({tag, "_fu"},    64'(CDB_FU_ID),  64'(fu));
        check_eq({tag, "_reg"},   64'(CDB_REG_ID), 64'(r));
        check_eq({tag, "_iss"},   64'(CDB_ISS_ID), 64'(iss));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 64'(cdb_valid),  64'd0);
        check_eq({tag, "_reg"},   64'(CDB_REG_ID), 64'd0);
        check_eq({tag, "_grant"}, 64'(grant_fu),   64'd0);
    endtask

    initial begin
        reset      = 1'b0;
        req_data   = '0;
        req_reg_id = '0;
        req_iss_id = '0;
        idle_inputs();

        // Reset state
        step(); step();
        check_idle("rst");
        check_eq("rst_cdb",   CDB, 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'h0);
        reset = 1'b1;
        #1;
        check_eq("rel_ready", 64'(req_ready), 64'hF);

        // All four FUs at once: round-robin FU0..FU3
        for (int k = 0; k < N; k++) set_req(k, 64'hA0 + 64'(k), 5'(k + 1), 32'(10 + k), 1'b0);
        step();
        idle_inputs();
        check_eq("rr_ready0", 64'(req_ready), 64'h1);
        check_eq("rr_pre",    64'(cdb_valid), 64'd0);
        step();
        check_bus("rr0", 4'd1, 5'd1, 32'd10);
        check_eq("rr0_data",  CDB, 64'hA0);
        check_eq("rr0_grant", 64'(grant_fu), 64'h1);
        check_eq("rr_ready1", 64'(req_ready), 64'h3);
        step();
        check_bus("rr1", 4'd2, 5'd2, 32'd11);
        check_eq("rr_ready2", 64'(req_ready), 64'h7);
        step();
        check_bus("rr2", 4'd3, 5'd3, 32'd12);
        step();
        check_bus("rr3", 4'd4, 5'd4, 32'd13);
        check_eq("rr3_grant", 64'(grant_fu), 64'h8);
        step();
        check_idle("rr_end");

        // FU2 streams 8 results back to back
        for (int i = 0; i < 8; i++) begin
            set_req(2, 64'hB00 + 64'(i), 5'd5, 32'(100 + i), 1'b0);
            check_eq("st_ready", 64'(req_ready[2]), 64'd1);
            if (i >= 2) check_bus("st", 4'd3, 5'd5, 32'(100 + i - 2));
            step();
        end
        idle_inputs();
        check_bus("st6", 4'd3, 5'd5, 32'd106);
        step();
        check_bus("st7", 4'd3, 5'd5, 32'd107);
        step();
        check_idle("st_end");

        // Mispredict: FU1 spec squashed, FU3 non-spec broadcast, FU0 spec input dropped
        set_req(1, 64'h111, 5'd7, 32'd200, 1'b1);
        set_req(3, 64'h333, 5'd9, 32'd201, 1'b0);
        step();
        idle_inputs();
        prediction_failed = 1'b1;
        set_req(0, 64'h000, 5'd3, 32'd202, 1'b1);
        check_eq("pf_ready", 64'(req_ready), 64'hD);
        step();
        idle_inputs();
        check_bus("pf_fu3", 4'd4, 5'd9, 32'd201);
        check_eq("pf_ready_after", 64'(req_ready), 64'hF);
        step();
        check_idle("pf_nofu1");
        step();
        check_idle("pf_nofu1b");

        // Register-0 request: accepted, never broadcast
        set_req(0, 64'hDEAD, 5'd0, 32'd300, 1'b0);
        check_eq("r0_ready", 64'(req_ready[0]), 64'd1);
        step();
        idle_inputs();
        check_eq("r0_ready_after", 64'(req_ready), 64'hF);
        step();
        check_idle("r0");

        // Issue-ID wrap: FU0 iss 2, FU1 iss FFFF_FFFE
        set_req(0, 64'h20, 5'd4, 32'h0000_0002, 1'b0);
        set_req(1, 64'h21, 5'd6, 32'hFFFF_FFFE, 1'b0);
        step();
        idle_inputs();
        step();
`ifdef CDB_ARB_AGE_PRIORITY_EN
        check_bus("age_first", 4'd2, 5'd6, 32'hFFFF_FFFE);
        step();
        check_bus("age_second", 4'd1, 5'd4, 32'h0000_0002);
`else
        check_bus("wrap_first", 4'd1, 5'd4, 32'h0000_0002);
        step();
        check_bus("wrap_second", 4'd2, 5'd6, 32'hFFFF_FFFE);
`endif
        step();
        check_idle("wrap_end");

        // Reset with three slots pending
        set_req(0, 64'h40, 5'd1, 32'd400, 1'b0);
        set_req(2, 64'h42, 5'd2, 32'd402, 1'b0);
        set_req(3, 64'h43, 5'd3, 32'd403, 1'b0);
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        check_eq("mr_ready_low", 64'(req_ready), 64'h0);
        step();
        check_idle("mr_out");
        reset = 1'b1;
        #1;
        check_eq("mr_ready_rel", 64'(req_ready), 64'hF);
        step();
        check_idle("mr_stale0");
        step();
        check_idle("mr_stale1");

        // Success clears spec marks so a later mispredict spares them
        set_req(1, 64'h51, 5'd11, 32'd500, 1'b1);
        set_req(2, 64'h52, 5'd12, 32'd501, 1'b1);
        step();
        idle_inputs();
        prediction_success = 1'b1;
        step();
        idle_inputs();
        prediction_failed = 1'b1;
        check_bus("ps_fu1", 4'd2, 5'd11, 32'd500);
        step();
        idle_inputs();
        check_bus("ps_fu2", 4'd3, 5'd12, 32'd501);
        step();
        check_idle("ps_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the execution functional units. Each unit hands its completed result to a one-entry holding slot through a valid/ready handshake. Each cycle the arbiter selects one pending slot and drives it onto the registered CDB outputs that every reservation station snoops. Pending speculative results are squashed on a branch mispredict.

## Interface
- N_FU, 4: number of requesting functional units, 2..8.
- FU_ID_BASE, 1: value of CDB_FU_ID for requester 0; requester k broadcasts FU ID FU_ID_BASE+k. Must fit in 4 bits.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low; state clears on a rising edge where reset==0.
- req_valid  in  N_FU  per-FU result valid.
- req_ready  out  N_FU  per-FU slot can accept.
- req_data  in  N_FU*64  results; FU k at [64k+63:64k].
- req_reg_id  in  N_FU*5  destination register per FU.
- req_iss_id  in  N_FU*32  issue ID per FU.
- req_spec  in  N_FU  result lies under an unresolved branch.
- prediction_failed  in  1  mispredict; squash speculative results.
- prediction_success  in  1  branch resolved correctly; clear speculative marks.
- CDB  out  64  broadcast data.
- CDB_REG_ID  out  5  broadcast destination; 0 means no broadcast.
- CDB_FU_ID  out  4  broadcast FU ID.
- CDB_ISS_ID  out  32  broadcast issue ID.
- cdb_valid  out  1  a broadcast is present this cycle.
- grant_fu  out  N_FU  one-hot of the slot broadcast this cycle, for perf counters.

## Operation
- Per-FU slot fields: valid, spec, data, reg_id, iss_id.
- req_ready[k] = slot k empty, or slot k is being granted this cycle. It is combinational from slot state and the grant. It does not depend on req_valid.
- Accept: req_valid[k] && req_ready[k] loads slot k at the clock edge.
- Accept exception: a request with req_reg_id==0 is accepted and discarded, so no slot is loaded. A register-0 broadcast would be ignored by the reservation stations anyway.
- Arbitration: only among valid slots that are not being squashed this cycle. At most one grant per cycle.
  - Default policy is round-robin.
  - rr_ptr holds the last granted index. Search order is rr_ptr+1, rr_ptr+2, ..., wrapping modulo N_FU.
  - rr_ptr updates only on a grant.
- Grant to slot k, registered at the next edge:
  - CDB <= data, CDB_REG_ID <= reg_id, CDB_FU_ID <= FU_ID_BASE+k, CDB_ISS_ID <= iss_id.
  - cdb_valid <= 1, grant_fu <= one-hot(k).
  - Slot k clears at the same edge unless it is refilled through the handshake.
- No grant: all CDB outputs are driven to 0 at the next edge, including CDB_REG_ID=0 and cdb_valid=0.
- prediction_failed in cycle t:
  - Every slot with spec=1 clears at the end of t and is not eligible for grant in t.
  - Incoming requests with req_spec=1 are accepted and discarded.
- prediction_success in cycle t:
  - All slot spec bits clear at the edge.
  - Incoming requests load with spec=0.
- Both prediction_failed and prediction_success asserted: prediction_failed wins.
- Reset values:
  - All slots invalid; rr_ptr=N_FU-1, so FU0 has first priority.
  - CDB=0, CDB_REG_ID=0, CDB_FU_ID=0, CDB_ISS_ID=0, cdb_valid=0, grant_fu=0.
  - req_ready=0 while reset==0; all ones in the first cycle after reset is released.

## Timing
- Accept at edge t, broadcast visible in cycle t+1 at the earliest. Minimum latency is 1 cycle.
- Throughput: one broadcast per cycle overall. A single FU sustains one result per cycle when it is granted every cycle, because ready stays high while its slot is granted.
- A slot that is held back stalls only its own FU (req_ready=0). Other FUs are unaffected.
- Worst-case wait with all N_FU slots pending under round-robin is N_FU-1 cycles.
- Reset asserted mid-operation discards all pending slots. No partial broadcast is emitted on the following cycle.

## Configuration
- CDB_ARB_AGE_PRIORITY_EN defined: grant goes to the oldest eligible slot.
  - Slot a is older than slot b when $signed(iss_id_a - iss_id_b) < 0 in 32-bit arithmetic, which is correct across issue-ID wrap-around.
  - Ties go to the lowest index.
  - rr_ptr is still maintained but unused.
- CDB_ARB_AGE_PRIORITY_EN undefined: pure round-robin as described in Operation.

## Test plan
- Reset, then FU0..FU3 all present valid in the same cycle with iss_id 10,11,12,13 → round-robin order on the CDB is FU0,1,2,3 in consecutive cycles with CDB_FU_ID 1,2,3,4. FU1..FU3 see req_ready=0 until their slot drains.
- FU2 streams one result per cycle for 8 cycles, other FUs idle → 8 back-to-back broadcasts, req_ready[2] constantly 1, CDB_ISS_ID values in order.
- FU1 holds spec=1 (reg 7) and FU3 holds spec=0 (reg 9); assert prediction_failed → FU1's result is never broadcast, FU3's is, and req_ready[1] is 1 next cycle.
- FU0 request with req_reg_id=0 → accepted, no broadcast, CDB_REG_ID stays 0, cdb_valid=0.
- With CDB_ARB_AGE_PRIORITY_EN defined: FU0 iss_id=32'h0000_0002 and FU1 iss_id=32'hFFFF_FFFE pending together → FU1 is broadcast first (older across wrap), then FU0.
- reset driven low while 3 slots are pending → the next cycle has cdb_valid=0 and all slots empty. After release, req_ready is all ones and no stale broadcast appears.
